// File: rtl/ras_pkg.sv
// Shared types, constants and helpers for the return-address-stack control stage.
package ras_pkg;

    localparam int PC_W = 32;

    localparam logic [2:0] RET_STEP_C = 3'd2;
    localparam logic [2:0] RET_STEP_N = 3'd4;

    typedef struct packed {
        logic push;
        logic pop;
        logic branch;
        logic close_valid;
        logic close_invalid;
    } ras_cmd_t;

    localparam ras_cmd_t RAS_CMD_IDLE = ras_cmd_t'(5'b00000);

    function automatic logic [2:0] ret_step(input logic is_c);
        return is_c ? RET_STEP_C : RET_STEP_N;
    endfunction

    function automatic logic [PC_W-1:0] ret_addr(input logic [PC_W-1:0] pc, input logic is_c);
        return pc + {{(PC_W-3){1'b0}}, ret_step(is_c)};
    endfunction

endpackage

// File: rtl/ras_ctrl_if.sv
// Fetch/backend/ras-facing bundle of ras_ctrl. RAS_CTRL_STATS_EN adds the statistics outputs.
interface ras_ctrl_if #(
    parameter int WIDTH         = 32,
    parameter int BRANCHES_ADDR = 4
);
    logic                   fetch_valid;
    logic                   fetch_is_call;
    logic                   fetch_is_ret;
    logic                   fetch_is_cond;
    logic                   fetch_is_c;
    logic [WIDTH-1:0]       fetch_pc;
    logic                   fetch_ready;
    logic                   resolve_valid;
    logic                   resolve_mispredict;
    logic                   ras_push;
    logic                   ras_pop;
    logic                   ras_branch;
    logic                   ras_close_valid;
    logic                   ras_close_invalid;
    logic [WIDTH-1:0]       ras_din;
    logic [WIDTH-1:0]       ras_dout;
    logic                   ras_empty;
    logic                   pred_valid;
    logic [WIDTH-1:0]       pred_target;
    logic [BRANCHES_ADDR:0] spec_depth;
`ifdef RAS_CTRL_STATS_EN
    logic [15:0]            stat_empty_pops;
    logic [15:0]            stat_flushes;
`endif

    modport master (
        output fetch_valid, fetch_is_call, fetch_is_ret, fetch_is_cond, fetch_is_c, fetch_pc,
        output resolve_valid, resolve_mispredict, ras_dout, ras_empty,
        input  fetch_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
        input  ras_din, pred_valid, pred_target, spec_depth
`ifdef RAS_CTRL_STATS_EN
        , input stat_empty_pops, stat_flushes
`endif
    );

    modport slave (
        input  fetch_valid, fetch_is_call, fetch_is_ret, fetch_is_cond, fetch_is_c, fetch_pc,
        input  resolve_valid, resolve_mispredict, ras_dout, ras_empty,
        output fetch_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
        output ras_din, pred_valid, pred_target, spec_depth
`ifdef RAS_CTRL_STATS_EN
        , output stat_empty_pops, stat_flushes
`endif
    );

endinterface

// File: rtl/ras_spec_tracker.sv
// Open-speculation depth counter; back-pressures conds so the ras branch fifo never overflows.
module ras_spec_tracker
    import ras_pkg::*;
#(
    parameter int MAXBRANCHES   = 16,
    parameter int BRANCHES_ADDR = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_valid,
    input  logic                   fetch_is_cond,
    input  logic                   resolve_valid,
    input  logic                   resolve_mispredict,
    output logic                   fetch_ready,
    output logic                   resolve_ok,
    output logic                   flush,
    output logic [BRANCHES_ADDR:0] spec_depth
);
    localparam int DW = BRANCHES_ADDR + 1;
    localparam logic [DW-1:0] DEPTH_MAX  = DW'(MAXBRANCHES);
    localparam logic [DW-1:0] DEPTH_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DEPTH_ONE  = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] depth_r;
    logic [DW-1:0] depth_next_s;
    logic          full_s;
    logic          resolve_any_s;
    logic          accept_cond_s;

    // Resolution qualification, ready generation and next depth; a resolve at depth 0 is ignored.
    always_comb begin
        full_s        = (depth_r == DEPTH_MAX);
        resolve_any_s = resolve_valid && (depth_r != DEPTH_ZERO);
        flush         = resolve_any_s && resolve_mispredict;
        resolve_ok    = resolve_any_s && !resolve_mispredict;
        fetch_ready   = !(fetch_is_cond && full_s && !resolve_valid);
        accept_cond_s = fetch_valid && fetch_ready && fetch_is_cond && !flush;
        depth_next_s  = depth_r;
        case ({flush, accept_cond_s, resolve_ok})
            3'b010:  depth_next_s = depth_r + DEPTH_ONE;
            3'b001:  depth_next_s = depth_r - DEPTH_ONE;
            3'b000,
            3'b011:  depth_next_s = depth_r;
            default: depth_next_s = DEPTH_ZERO;
        endcase
    end

    // Depth register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_r <= DEPTH_ZERO;
        end else begin
            depth_r <= depth_next_s;
        end
    end

    assign spec_depth = depth_r;

    a_no_resolve_when_idle: assert property (@(posedge clk) disable iff (rst)
        !(resolve_valid && (depth_r == DEPTH_ZERO)));

endmodule

// File: rtl/ras_ctrl.sv
// Control stage in front of the return address stack: issues ras commands, tracks speculation,
// and turns popped stack data into a return-target prediction. RAS_CTRL_STATS_EN adds counters.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MAXBRANCHES   = 16,
    parameter int BRANCHES_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst,
    ras_ctrl_if.slave  bus
);
    logic                   fetch_ready_s;
    logic                   resolve_ok_s;
    logic                   flush_s;
    logic [BRANCHES_ADDR:0] spec_depth_s;
    logic                   fetch_ok_s;
    logic [WIDTH-1:0]       ret_addr_s;
    logic [WIDTH-1:0]       pred_target_s;
    ras_cmd_t               cmd_next_s;
    ras_cmd_t               cmd_r;
    logic [WIDTH-1:0]       din_r;
    logic                   pend_pred_r;

    ras_spec_tracker #(
        .MAXBRANCHES   (MAXBRANCHES),
        .BRANCHES_ADDR (BRANCHES_ADDR)
    ) u_tracker (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (bus.fetch_valid),
        .fetch_is_cond      (bus.fetch_is_cond),
        .resolve_valid      (bus.resolve_valid),
        .resolve_mispredict (bus.resolve_mispredict),
        .fetch_ready        (fetch_ready_s),
        .resolve_ok         (resolve_ok_s),
        .flush              (flush_s),
        .spec_depth         (spec_depth_s)
    );

    if (WIDTH == PC_W) begin : g_pkg_addr
        assign ret_addr_s = ret_addr(bus.fetch_pc, bus.fetch_is_c);
    end else begin : g_wide_addr
        assign ret_addr_s = bus.fetch_pc + WIDTH'(ret_step(bus.fetch_is_c));
    end

    // Command decode; a cond takes precedence over call/ret, a mispredict drops the fetch event.
    always_comb begin
        cmd_next_s = RAS_CMD_IDLE;
        fetch_ok_s = bus.fetch_valid && fetch_ready_s && !flush_s;
        if (fetch_ok_s) begin
            if (bus.fetch_is_cond) begin
                cmd_next_s.branch = 1'b1;
            end else begin
                cmd_next_s.push = bus.fetch_is_call;
                cmd_next_s.pop  = bus.fetch_is_ret;
            end
        end else begin
            cmd_next_s = RAS_CMD_IDLE;
        end
        cmd_next_s.close_valid   = resolve_ok_s;
        cmd_next_s.close_invalid = flush_s;
    end

    // Command/data registers and the pending-prediction flag set while a pop is on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r       <= RAS_CMD_IDLE;
            din_r       <= {WIDTH{1'b0}};
            pend_pred_r <= 1'b0;
        end else begin
            cmd_r <= cmd_next_s;
            if (cmd_next_s.push) begin
                din_r <= ret_addr_s;
            end
            pend_pred_r <= cmd_r.pop && !bus.ras_empty && !flush_s;
        end
    end

    // Stack read data arrives one cycle after the pop and is forwarded only while pending.
    always_comb begin
        pred_target_s = {WIDTH{1'b0}};
        if (pend_pred_r) begin
            pred_target_s = bus.ras_dout;
        end else begin
            pred_target_s = {WIDTH{1'b0}};
        end
    end

    assign bus.fetch_ready       = fetch_ready_s;
    assign bus.ras_push          = cmd_r.push;
    assign bus.ras_pop           = cmd_r.pop;
    assign bus.ras_branch        = cmd_r.branch;
    assign bus.ras_close_valid   = cmd_r.close_valid;
    assign bus.ras_close_invalid = cmd_r.close_invalid;
    assign bus.ras_din           = din_r;
    assign bus.pred_valid        = pend_pred_r;
    assign bus.pred_target       = pred_target_s;
    assign bus.spec_depth        = spec_depth_s;

`ifdef RAS_CTRL_STATS_EN
    logic [15:0] empty_pops_r;
    logic [15:0] flushes_r;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_pops_r <= 16'd0;
            flushes_r    <= 16'd0;
        end else begin
            if (cmd_r.pop && bus.ras_empty && (empty_pops_r != 16'hFFFF)) begin
                empty_pops_r <= empty_pops_r + 16'd1;
            end
            if (cmd_r.close_invalid && (flushes_r != 16'hFFFF)) begin
                flushes_r <= flushes_r + 16'd1;
            end
        end
    end

    assign bus.stat_empty_pops = empty_pops_r;
    assign bus.stat_flushes    = flushes_r;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed vector table, hand-written corner sequences, random run vs a model.
module tb_ras_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ras_ctrl_if #(.WIDTH(32), .BRANCHES_ADDR(4)) bus();

    ras_ctrl #(.WIDTH(32), .MAXBRANCHES(16), .BRANCHES_ADDR(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          fv, call, ret, cond, c;
        logic [31:0] pc;
        bit          rv, mis;
        logic [31:0] dout;
        bit          empty;
    } in_t;

    typedef struct {
        in_t         in;
        bit          push, pop, br, cv, ci;
        logic [31:0] din;
        bit          pv;
        logic [31:0] pt;
        bit          rdy;
        int          depth;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: expected values of the registered outputs in the current cycle.
    in_t         cur;
    int          m_depth;
    bit          m_push, m_pop, m_br, m_cv, m_ci, m_pend;
    logic [31:0] m_din;
    int          m_ep, m_fl;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic in_t mk(bit fv, bit call, bit ret, bit cond, bit c, logic [31:0] pc,
                               bit rv, bit mis, logic [31:0] dout, bit empty);
        in_t v;
        v.fv = fv; v.call = call; v.ret = ret; v.cond = cond; v.c = c; v.pc = pc;
        v.rv = rv; v.mis = mis; v.dout = dout; v.empty = empty;
        return v;
    endfunction

    function automatic vec_t mv(in_t in, bit push, bit pop, bit br, bit cv, bit ci,
                                logic [31:0] din, bit pv, logic [31:0] pt, bit rdy, int depth);
        vec_t v;
        v.in = in; v.push = push; v.pop = pop; v.br = br; v.cv = cv; v.ci = ci;
        v.din = din; v.pv = pv; v.pt = pt; v.rdy = rdy; v.depth = depth;
        return v;
    endfunction

    function automatic in_t idle(logic [31:0] dout, bit empty);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, dout, empty);
    endfunction

    task automatic model_reset();
        m_depth = 0; m_push = 0; m_pop = 0; m_br = 0; m_cv = 0; m_ci = 0; m_pend = 0;
        m_din = 32'h0; m_ep = 0; m_fl = 0;
    endtask

    // Drive one cycle's inputs and compare every output against the model.
    task automatic apply(input in_t v);
        bit exp_rdy;
        cur = v;
        bus.fetch_valid = v.fv; bus.fetch_is_call = v.call; bus.fetch_is_ret = v.ret;
        bus.fetch_is_cond = v.cond; bus.fetch_is_c = v.c; bus.fetch_pc = v.pc;
        bus.resolve_valid = v.rv; bus.resolve_mispredict = v.mis;
        bus.ras_dout = v.dout; bus.ras_empty = v.empty;
        #1;
        exp_rdy = !(v.cond && (m_depth == 16) && !v.rv);
        chk("m_ready",  64'(bus.fetch_ready),       64'(exp_rdy));
        chk("m_push",   64'(bus.ras_push),          64'(m_push));
        chk("m_pop",    64'(bus.ras_pop),           64'(m_pop));
        chk("m_branch", 64'(bus.ras_branch),        64'(m_br));
        chk("m_cv",     64'(bus.ras_close_valid),   64'(m_cv));
        chk("m_ci",     64'(bus.ras_close_invalid), 64'(m_ci));
        chk("m_din",    64'(bus.ras_din),           64'(m_din));
        chk("m_depth",  64'(bus.spec_depth),        64'(m_depth));
        chk("m_pv",     64'(bus.pred_valid),        64'(m_pend));
        chk("m_pt",     64'(bus.pred_target),       64'(m_pend ? v.dout : 32'h0));
`ifdef RAS_CTRL_STATS_EN
        chk("m_stat_ep", 64'(bus.stat_empty_pops), 64'(m_ep));
        chk("m_stat_fl", 64'(bus.stat_flushes),    64'(m_fl));
`endif
    endtask

    // Advance the model by the behavioural rules and move to the next cycle's sampling point.
    task automatic adv();
        bit ready, legal, flsh, ok;
        if (rst) begin
            model_reset();
        end else begin
            ready = !(cur.cond && (m_depth == 16) && !cur.rv);
            legal = cur.rv && (m_depth > 0);
            flsh  = legal && cur.mis;
            ok    = cur.fv && ready && !flsh;
            if (m_pop && cur.empty && (m_ep < 65535)) m_ep++;
            if (m_ci && (m_fl < 65535)) m_fl++;
            m_pend = m_pop && !cur.empty && !flsh;
            m_br   = ok && cur.cond;
            m_push = ok && cur.call && !cur.cond;
            m_pop  = ok && cur.ret && !cur.cond;
            m_cv   = legal && !cur.mis;
            m_ci   = flsh;
            if (m_push) m_din = cur.pc + (cur.c ? 32'd2 : 32'd4);
            if (flsh) m_depth = 0;
            else      m_depth = m_depth + (m_br ? 1 : 0) - (m_cv ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;
        model_reset();
        cur = idle(32'h0, 1'b0);
        apply(cur);
        rst = 1'b1;
        @(negedge clk);
        apply(idle(32'h0, 1'b0)); adv();
        apply(idle(32'h0, 1'b0)); adv();
        rst = 1'b0;

        //             fv call ret cond c  pc           rv mis dout         empty
        tbl[0]  = mv(mk(1, 1, 0, 0, 0, 32'h1000, 0, 0, 32'h0, 0),    0,0,0,0,0, 32'h0,    0, 32'h0,    1, 0);
        tbl[1]  = mv(mk(1, 1, 0, 0, 1, 32'h2000, 0, 0, 32'h0, 0),    1,0,0,0,0, 32'h1004, 0, 32'h0,    1, 0);
        tbl[2]  = mv(idle(32'h0, 0),                                  1,0,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[3]  = mv(mk(1, 0, 1, 0, 0, 32'h1008, 0, 0, 32'h0, 0),    0,0,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[4]  = mv(idle(32'h1004, 0),                               0,1,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[5]  = mv(idle(32'h1004, 0),                               0,0,0,0,0, 32'h2002, 1, 32'h1004, 1, 0);
        tbl[6]  = mv(idle(32'h1004, 0),                               0,0,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[7]  = mv(mk(1, 0, 1, 0, 0, 32'h1100, 0, 0, 32'h0, 1),    0,0,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[8]  = mv(idle(32'h5A5A, 1),                               0,1,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[9]  = mv(idle(32'h5A5A, 1),                               0,0,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[10] = mv(mk(1, 1, 1, 0, 0, 32'h3000, 0, 0, 32'h0, 0),    0,0,0,0,0, 32'h2002, 0, 32'h0,    1, 0);
        tbl[11] = mv(idle(32'hABCD, 0),                               1,1,0,0,0, 32'h3004, 0, 32'h0,    1, 0);
        tbl[12] = mv(idle(32'hABCD, 0),                               0,0,0,0,0, 32'h3004, 1, 32'hABCD, 1, 0);
        tbl[13] = mv(mk(1, 1, 0, 1, 1, 32'h4000, 0, 0, 32'h0, 0),    0,0,0,0,0, 32'h3004, 0, 32'h0,    1, 0);
        tbl[14] = mv(idle(32'h0, 0),                                  0,0,1,0,0, 32'h3004, 0, 32'h0,    1, 1);
        tbl[15] = mv(idle(32'h0, 0),                                  0,0,0,0,0, 32'h3004, 0, 32'h0,    1, 1);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].in);
            chk($sformatf("t%0d_push", i),   64'(bus.ras_push),          64'(tbl[i].push));
            chk($sformatf("t%0d_pop", i),    64'(bus.ras_pop),           64'(tbl[i].pop));
            chk($sformatf("t%0d_branch", i), 64'(bus.ras_branch),        64'(tbl[i].br));
            chk($sformatf("t%0d_cv", i),     64'(bus.ras_close_valid),   64'(tbl[i].cv));
            chk($sformatf("t%0d_ci", i),     64'(bus.ras_close_invalid), 64'(tbl[i].ci));
            chk($sformatf("t%0d_din", i),    64'(bus.ras_din),           64'(tbl[i].din));
            chk($sformatf("t%0d_pv", i),     64'(bus.pred_valid),        64'(tbl[i].pv));
            chk($sformatf("t%0d_pt", i),     64'(bus.pred_target),       64'(tbl[i].pt));
            chk($sformatf("t%0d_ready", i),  64'(bus.fetch_ready),       64'(tbl[i].rdy));
            chk($sformatf("t%0d_depth", i),  64'(bus.spec_depth),        64'(tbl[i].depth));
`ifdef RAS_CTRL_STATS_EN
            if (i == 9) chk("t9_stat_empty_pops", 64'(bus.stat_empty_pops), 64'd1);
`endif
            adv();
        end

        // Fill to the speculation limit, then probe back-pressure and a freeing resolve.
        for (int i = 0; i < 15; i++) begin
            apply(mk(1, 0, 0, 1, 0, 32'h8000 + 32'(i * 4), 0, 0, 32'h0, 0)); adv();
        end
        apply(idle(32'h0, 0));
        chk("full_depth", 64'(bus.spec_depth), 64'd16);
        adv();
        apply(mk(1, 0, 0, 1, 0, 32'h9000, 0, 0, 32'h0, 0));
        chk("full_ready_low", 64'(bus.fetch_ready), 64'd0);
        adv();
        apply(mk(1, 0, 0, 1, 0, 32'h9000, 1, 0, 32'h0, 0));
        chk("full_resolve_ready", 64'(bus.fetch_ready), 64'd1);
        adv();
        apply(idle(32'h0, 0));
        chk("full_branch", 64'(bus.ras_branch), 64'd1);
        chk("full_cv", 64'(bus.ras_close_valid), 64'd1);
        chk("full_depth_hold", 64'(bus.spec_depth), 64'd16);
        adv();

        // Drain to depth 3, then mispredict while a pop is outstanding and a call is fetched.
        for (int i = 0; i < 13; i++) begin
            apply(mk(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 0)); adv();
        end
        apply(mk(1, 0, 1, 0, 0, 32'hA000, 0, 0, 32'h0, 0));
        chk("pre_flush_depth", 64'(bus.spec_depth), 64'd3);
        adv();
        apply(mk(1, 1, 0, 0, 0, 32'h6000, 1, 1, 32'h1234, 0));
        chk("pre_flush_pop", 64'(bus.ras_pop), 64'd1);
        adv();
        apply(idle(32'h1234, 0));
        chk("flush_ci", 64'(bus.ras_close_invalid), 64'd1);
        chk("flush_push", 64'(bus.ras_push), 64'd0);
        chk("flush_depth", 64'(bus.spec_depth), 64'd0);
        chk("flush_pv", 64'(bus.pred_valid), 64'd0);
        adv();
        apply(idle(32'h1234, 0));
        chk("flush_pv_next", 64'(bus.pred_valid), 64'd0);
        adv();

        // Asynchronous reset while a pop and a pending prediction are both live.
        apply(mk(1, 0, 1, 0, 0, 32'hB000, 0, 0, 32'h0, 0)); adv();
        apply(mk(1, 0, 1, 0, 0, 32'hB004, 0, 0, 32'h0, 0)); adv();
        apply(idle(32'h7777, 0));
        chk("prerst_pop", 64'(bus.ras_pop), 64'd1);
        chk("prerst_pv", 64'(bus.pred_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_pop", 64'(bus.ras_pop), 64'd0);
        chk("rst_pv", 64'(bus.pred_valid), 64'd0);
        chk("rst_pt", 64'(bus.pred_target), 64'd0);
        chk("rst_din", 64'(bus.ras_din), 64'd0);
        chk("rst_ready", 64'(bus.fetch_ready), 64'd1);
        adv();
        apply(idle(32'h7777, 0)); adv();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(idle(32'h7777, 0));
            chk("postrst_pv", 64'(bus.pred_valid), 64'd0);
            adv();
        end

        // Random traffic against the model; resolves are only offered while levels are open.
        for (int i = 0; i < 4000; i++) begin
            v.fv    = ($urandom_range(0, 3) != 0);
            v.cond  = ($urandom_range(0, 9) < 4);
            v.call  = ($urandom_range(0, 9) < 3);
            v.ret   = ($urandom_range(0, 9) < 3);
            v.c     = $urandom_range(0, 1) == 1;
            v.pc    = $urandom;
            v.rv    = (m_depth > 0) && ($urandom_range(0, 9) < (i < 2000 ? 2 : 4));
            v.mis   = ($urandom_range(0, 19) == 0);
            v.dout  = $urandom;
            v.empty = ($urandom_range(0, 9) < 3);
            apply(v);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Control stage directly upstream of the return address stack (ras).
- Converts predecoded fetch events and backend branch resolutions into the ras command signals: push, pop, branch, close_valid, close_invalid and din.
- Captures the stack output as a return-target prediction for fetch.
- Tracks open speculation depth and back-pressures fetch, so the ras branch fifo can never overflow.

Parameters:
- WIDTH, 32, PC / return-address width.
- MAXBRANCHES, 16, maximum open speculation levels; equals the ras branch fifo depth.
- BRANCHES_ADDR, 4, width of the depth counter; spec_depth is BRANCHES_ADDR+1 bits so it can hold MAXBRANCHES.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  a predecoded instruction is presented this cycle.
- fetch_is_call  in  1  instruction is a call (link write).
- fetch_is_ret  in  1  instruction is a return.
- fetch_is_cond  in  1  instruction opens a speculation level.
- fetch_is_c  in  1  compressed instruction: return address is pc+2, else pc+4.
- fetch_pc  in  WIDTH  instruction PC.
- fetch_ready  out  1  event accepted this cycle.
- resolve_valid  in  1  oldest open speculation level resolves.
- resolve_mispredict  in  1  that resolution was wrong.
- ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid  out  1 each  ras commands (registered).
- ras_din  out  WIDTH  return address to push (registered).
- ras_dout  in  WIDTH  ras read data.
- ras_empty  in  1  ras empty flag.
- pred_valid  out  1  pred_target is valid this cycle.
- pred_target  out  WIDTH  predicted return target.
- spec_depth  out  BRANCHES_ADDR+1  open speculation levels.

Behaviour:
- Reset (async): all ras_* command outputs 0, ras_din 0, pred_valid 0, pred_target 0, spec_depth 0, internal pend_pred 0. fetch_ready is combinational, so it reads 1 during reset release.
- Acceptance: an event is accepted when fetch_valid && fetch_ready.
- fetch_ready = 0 only when fetch_is_cond && spec_depth==MAXBRANCHES && !resolve_valid. A same-cycle resolve frees a slot.
- Command latency: all ras commands are registered, asserted exactly one cycle after acceptance and held for exactly one cycle.
- Accepted cond: ras_branch=1. Any call/ret on the same instruction is ignored; cond has precedence.
- Accepted call: ras_push=1, ras_din = fetch_pc + (fetch_is_c ? 2 : 4), modulo 2^WIDTH.
- Accepted ret: ras_pop=1.
- Call and ret together: push and pop asserted in the same cycle (replace top). pred still produced.
- Resolution:
  - resolve_valid && !resolve_mispredict: ras_close_valid=1 next cycle; spec_depth decrements.
  - resolve_valid && resolve_mispredict: ras_close_invalid=1 next cycle; spec_depth becomes 0.
  - Any fetch event in the same cycle is dropped: no push/pop/branch issued. pend_pred cleared; pred_valid forced 0 next cycle.
  - resolve_valid with spec_depth==0 is illegal: ignored, depth stays 0. Assertion in simulation.
- Depth arithmetic: an accepted cond and a correct resolve in the same cycle leave depth unchanged, with both ras_branch and ras_close_valid asserted. Depth never wraps.
- Prediction pipeline (ras read has 1-cycle latency):
  - Cycle t+1 (ras_pop high): pend_pred <= !ras_empty.
  - Cycle t+2: pred_valid = pend_pred, pred_target = ras_dout captured that cycle. Held for one cycle only.
  - Pop on an empty stack: pop still issued; pred_valid stays 0.
- Back-to-back rets on consecutive cycles yield consecutive pred_valid pulses.

Optional Feature:
- RAS_CTRL_STATS_EN defined: adds outputs stat_empty_pops and stat_flushes, 16 bits each, saturating, reset to 0.
  - stat_empty_pops increments on a pop issued with ras_empty=1.
  - stat_flushes increments on each ras_close_invalid.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ras_pkg:
  - ras_cmd_t, a packed struct {push, pop, branch, close_valid, close_invalid}.
  - Constants RET_STEP_C=2 and RET_STEP_N=4.
  - Function ret_addr(pc, is_c).
- One sub-module, ras_spec_tracker: depth counter, full detection, fetch_ready, and the illegal-resolve assertion.

Test Plan:
- Reset then call at pc=0x1000, is_c=0 -> ras_push=1 with ras_din=0x1004 one cycle later; call at pc=0x2000, is_c=1 -> ras_din=0x2002.
- Call 0x1000, then ret two cycles later (ras model returns 0x1004) -> ras_pop one cycle after the ret; pred_valid=1 with pred_target=0x1004 two cycles after the ret.
- Ret from reset with ras_empty=1 -> ras_pop=1, pred_valid stays 0; with STATS_EN, stat_empty_pops=1.
- 16 accepted conds -> spec_depth=16; a 17th cond -> fetch_ready=0; the same cond with resolve_valid=1, mispredict=0 -> accepted, ras_branch and ras_close_valid both 1, depth stays 16.
- Depth=3, resolve_mispredict concurrent with an accepted call -> ras_close_invalid=1, ras_push=0, spec_depth=0, pred_valid=0.
- Assert rst mid-stream while ras_pop=1 and pend_pred=1 -> all outputs 0 immediately (async), with no pred_valid pulse after release.
